uart_tx_arbiter: RTL and testbench

//  UART transmit arbiter and emitter for the rv32 top level. It shares one TX line between two

---
 rtl/uart_tx_arbiter.sv | 146 ++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// Two-port round-robin byte arbiter feeding a small FIFO and an 8N1 UART serialiser.
// Request ports use the opt-byte convention: bit 8 = valid, bits 7:0 = data.
module uart_tx_arbiter #(
   parameter int CLK_PER_BIT = 217,
   parameter int FIFO_AW     = 2
) (
   input  logic               CLK,
   input  logic               RST_N,
   input  logic [8:0]         req0_opt_byte,
   output logic               req0_ready,
   input  logic [8:0]         req1_opt_byte,
   output logic               req1_ready,
   output logic               uart_line_out,
   output logic               tx_busy,
   output logic [FIFO_AW:0]   fifo_level
);

   localparam int DEPTH = 2 ** FIFO_AW;
   localparam int BW    = (CLK_PER_BIT > 2) ? $clog2(CLK_PER_BIT) : 1;
   localparam logic [BW-1:0]    BAUD_LAST = BW'(CLK_PER_BIT - 1);
   localparam logic [FIFO_AW:0] FULL_LVL  = (FIFO_AW + 1)'(DEPTH);

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;

   state_e              state_q, state_d;
   logic [BW-1:0]       baud_cnt_q, baud_cnt_d;
   logic [2:0]          bit_idx_q, bit_idx_d;
   logic [7:0]          shift_q, shift_d;
   logic                line_q, line_d;
   logic                last_grant_q, last_grant_d;
   logic [FIFO_AW:0]    wr_ptr_q, wr_ptr_d;
   logic [FIFO_AW:0]    rd_ptr_q, rd_ptr_d;
   logic [7:0]          mem_q [DEPTH];

   logic                full, empty, grant0, grant1, push, pop, baud_end;
   logic [7:0]          push_data, head;

   assign fifo_level    = wr_ptr_q - rd_ptr_q;
   assign head          = mem_q[rd_ptr_q[FIFO_AW-1:0]];
   assign req0_ready    = grant0;
   assign req1_ready    = grant1;
   assign uart_line_out = line_q;
   assign tx_busy       = (state_q != IDLE) || !empty;

   // Full is judged on the pre-edge level, so a same-cycle pop never frees a slot early.
   always_comb begin
      full         = (fifo_level == FULL_LVL);
      empty        = (fifo_level == '0);
      grant0       = 1'b0;
      grant1       = 1'b0;
      if (!full) begin
         if (req0_opt_byte[8] && (!req1_opt_byte[8] || last_grant_q)) grant0 = 1'b1;
         else if (req1_opt_byte[8])                                    grant1 = 1'b1;
      end
      push         = grant0 || grant1;
      push_data    = grant0 ? req0_opt_byte[7:0] : req1_opt_byte[7:0];
      last_grant_d = push ? grant1 : last_grant_q;
      wr_ptr_d     = push ? wr_ptr_q + (FIFO_AW + 1)'(1) : wr_ptr_q;
   end

   always_comb begin
      state_d    = state_q;
      baud_cnt_d = baud_cnt_q;
      bit_idx_d  = bit_idx_q;
      shift_d    = shift_q;
      pop        = 1'b0;
      baud_end   = (baud_cnt_q == BAUD_LAST);
      unique case (state_q)
         IDLE: begin
            if (!empty) begin
               pop        = 1'b1;
               shift_d    = head;
               baud_cnt_d = '0;
               state_d    = START;
            end
         end
         START: begin
            if (baud_end) begin
               baud_cnt_d = '0;
               bit_idx_d  = '0;
               state_d    = DATA;
            end else begin
               baud_cnt_d = baud_cnt_q + BW'(1);
            end
         end
         DATA: begin
            if (baud_end) begin
               baud_cnt_d = '0;
               if (bit_idx_q == 3'd7) begin
                  state_d = STOP;
               end else begin
                  shift_d   = {1'b0, shift_q[7:1]};
                  bit_idx_d = bit_idx_q + 3'd1;
               end
            end else begin
               baud_cnt_d = baud_cnt_q + BW'(1);
            end
         end
         STOP: begin
            if (baud_end) begin
               baud_cnt_d = '0;
               if (!empty) begin
                  pop     = 1'b1;
                  shift_d = head;
                  state_d = START;
               end else begin
                  state_d = IDLE;
               end
            end else begin
               baud_cnt_d = baud_cnt_q + BW'(1);
            end
         end
         default: state_d = IDLE;
      endcase
      rd_ptr_d = pop ? rd_ptr_q + (FIFO_AW + 1)'(1) : rd_ptr_q;
      // The line follows the registered state, one cycle behind each transition.
      line_d   = (state_q == START) ? 1'b0 : (state_q == DATA) ? shift_q[0] : 1'b1;
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state_q      <= IDLE;
         baud_cnt_q   <= '0;
         bit_idx_q    <= '0;
         shift_q      <= '0;
         line_q       <= 1'b1;
         last_grant_q <= 1'b1;
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
      end else begin
         state_q      <= state_d;
         baud_cnt_q   <= baud_cnt_d;
         bit_idx_q    <= bit_idx_d;
         shift_q      <= shift_d;
         line_q       <= line_d;
         last_grant_q <= last_grant_d;
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
      end
   end

   always_ff @(posedge CLK) begin
      if (push) mem_q[wr_ptr_q[FIFO_AW-1:0]] <= push_data;
   end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: queue/timestamp reference model checked every cycle,
// directed scenarios with literal expectations, then randomized two-port traffic.
module tb_uart_tx_arbiter;

   localparam int CPB   = 4;
   localparam int AW    = 2;
   localparam int DEPTH = 4;
   localparam int FRAME = 10 * CPB;

   logic          CLK = 1'b0;
   logic          RST_N = 1'b0;
   logic [8:0]    req0_opt_byte = '0;
   logic [8:0]    req1_opt_byte = '0;
   logic          req0_ready, req1_ready, uart_line_out, tx_busy;
   logic [AW:0]   fifo_level;

   uart_tx_arbiter #(.CLK_PER_BIT(CPB), .FIFO_AW(AW)) dut (
      .CLK           (CLK),
      .RST_N         (RST_N),
      .req0_opt_byte (req0_opt_byte),
      .req0_ready    (req0_ready),
      .req1_opt_byte (req1_opt_byte),
      .req1_ready    (req1_ready),
      .uart_line_out (uart_line_out),
      .tx_busy       (tx_busy),
      .fifo_level    (fifo_level)
   );

   always #5 CLK = ~CLK;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: byte queue plus the edge at which the current frame was popped.
   logic [7:0] q[$];
   bit         active  = 1'b0;
   bit         frame_v = 1'b0;
   bit         last_g  = 1'b1;
   int         pop_edge = 0;
   int         edge_n   = 0;
   logic [7:0] cur = '0;
   bit         mg0 = 1'b0, mg1 = 1'b0;
   logic [8:0] s0, s1;

   function automatic logic exp_line();
      int k;
      if (!frame_v) return 1'b1;
      if (edge_n < pop_edge + 1 || edge_n >= pop_edge + 1 + FRAME) return 1'b1;
      k = (edge_n - pop_edge - 1) / CPB;
      if (k == 0) return 1'b0;
      if (k == 9) return 1'b1;
      return cur[k-1];
   endfunction

   function automatic bit pop_next();
      return (q.size() > 0) && (!active || (edge_n + 1 == pop_edge + FRAME));
   endfunction

   initial begin
      bit full;
      forever begin
         @(negedge CLK);
         if (!RST_N) begin
            q.delete();
            active = 1'b0; frame_v = 1'b0; last_g = 1'b1; mg0 = 1'b0; mg1 = 1'b0;
            chk("rst_line",  32'(uart_line_out), 32'd1);
            chk("rst_level", 32'(fifo_level),    32'd0);
            chk("rst_busy",  32'(tx_busy),       32'd0);
         end else begin
            s0   = req0_opt_byte;
            s1   = req1_opt_byte;
            full = (q.size() == DEPTH);
            mg0  = !full && s0[8] && (!s1[8] || last_g);
            mg1  = !full && s1[8] && (!s0[8] || !last_g);
            chk("ready0", 32'(req0_ready),    32'(mg0));
            chk("ready1", 32'(req1_ready),    32'(mg1));
            chk("level",  32'(fifo_level),    32'(q.size()));
            chk("busy",   32'(tx_busy),       32'(active || q.size() > 0));
            chk("line",   32'(uart_line_out), 32'(exp_line()));
         end
         @(posedge CLK);
         edge_n++;
         if (RST_N) begin
            if (active && edge_n == pop_edge + FRAME) begin
               if (q.size() > 0) begin cur = q.pop_front(); pop_edge = edge_n; end
               else active = 1'b0;
            end else if (!active && q.size() > 0) begin
               cur = q.pop_front(); pop_edge = edge_n; active = 1'b1; frame_v = 1'b1;
            end
            if (mg0) begin q.push_back(s0[7:0]); last_g = 1'b0; end
            if (mg1) begin q.push_back(s1[7:0]); last_g = 1'b1; end
         end
      end
   end

   task automatic step(input logic [8:0] r0, input logic [8:0] r1);
      @(posedge CLK);
      #1;
      req0_opt_byte = r0;
      req1_opt_byte = r1;
   endtask

   task automatic wait_idle(input string name);
      int k = 0;
      while ((active || q.size() > 0) && k < 2000) begin
         @(negedge CLK);
         k++;
      end
      chk(name, 32'(k < 2000), 32'd1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, failures so far %0d", n_fail);
      $fatal(1, "watchdog");
   end

   initial begin
      logic [9:0] fb;
      logic [8:0] p0, p1;
      int ng, k, stall, grants, sent, same_cnt;
      bit same_prev, v;
      logic [7:0] val;

      repeat (3) @(posedge CLK);
      #2 RST_N = 1'b1;

      // 1: single byte 0x55, literal waveform and busy timing
      wait_idle("t1_idle");
      step(9'h155, 9'h000);
      @(negedge CLK);
      chk("t1_ready", 32'(req0_ready), 32'd1);
      step(9'h055, 9'h000);
      fb = 10'b1010101010;
      for (int j = 0; j < 44; j++) begin
         @(negedge CLK);
         if (j < 2 || j >= 42) chk("t1_line", 32'(uart_line_out), 32'd1);
         else                  chk("t1_line", 32'(uart_line_out), 32'(fb[(j-2)/4]));
         chk("t1_busy", 32'(tx_busy), 32'(j <= 40));
      end

      // 4: data without valid bit is ignored
      wait_idle("t4_idle");
      for (int i = 0; i < 5; i++) begin
         step(9'h0FF, 9'h000);
         @(negedge CLK);
         chk("t4_ready", 32'(req0_ready),    32'd0);
         chk("t4_level", 32'(fifo_level),    32'd0);
         chk("t4_line",  32'(uart_line_out), 32'd1);
      end
      step(9'h000, 9'h000);

      // 3: fill while transmitting, ready held low until the frame-end pop
      wait_idle("t3_idle");
      grants = 0; stall = 0; val = 8'h30; k = 0;
      while (grants < 6 && k < 200) begin
         @(posedge CLK); #1;
         if (mg1) begin grants++; val++; end
         req1_opt_byte = (grants < 6) ? {1'b1, val} : 9'h000;
         @(negedge CLK);
         if (req1_opt_byte[8] && !req1_ready) begin
            if (stall == 0) chk("t3_full_level", 32'(fifo_level), 32'd4);
            stall++;
         end
         k++;
      end
      chk("t3_grants", 32'(grants), 32'd6);
      chk("t3_stall",  32'(stall),  32'd37);
      step(9'h000, 9'h000);

      // 5: async reset in the middle of data bit 3
      wait_idle("t5_idle");
      step(9'h100, 9'h000);
      step(9'h000, 9'h000);
      repeat (19) @(posedge CLK);
      #2;
      chk("t5_pre_line", 32'(uart_line_out), 32'd0);
      RST_N = 1'b0;
      #1;
      chk("t5_line",  32'(uart_line_out), 32'd1);
      chk("t5_level", 32'(fifo_level),    32'd0);
      chk("t5_busy",  32'(tx_busy),       32'd0);
      @(posedge CLK);
      #2 RST_N = 1'b1;

      // 2: both held, round robin from reset, back-to-back frames
      ng = 0; k = 0;
      while (ng < 6 && k < 300) begin
         step(9'h1AA, 9'h1BB);
         @(negedge CLK);
         if (req0_ready || req1_ready) begin
            chk("t2_alt", 32'({req1_ready, req0_ready}), (ng % 2 == 0) ? 32'd1 : 32'd2);
            ng++;
         end
         k++;
      end
      chk("t2_grants", 32'(ng), 32'd6);
      step(9'h000, 9'h000);

      // 6: push and pop on the same edge at level 2, 8 bytes in order
      wait_idle("t6_idle");
      sent = 0; same_cnt = 0; same_prev = 1'b0; k = 0;
      while (sent < 8 && k < 1000) begin
         @(posedge CLK); #1;
         if (same_prev) begin
            chk("t6_level", 32'(fifo_level), 32'd2);
            same_cnt++;
         end
         if (mg0) sent++;
         v = (sent < 8) && (q.size() < 2 || (q.size() == 2 && pop_next()));
         same_prev = v && (q.size() == 2);
         req0_opt_byte = {v, 8'(8'hC0 + sent)};
         k++;
      end
      chk("t6_same", 32'(same_cnt), 32'd5);
      step(9'h000, 9'h000);
      wait_idle("t6_drain");

      // randomized traffic: ungranted valid requests are held
      p0 = '0; p1 = '0;
      for (int i = 0; i < 400; i++) begin
         @(posedge CLK); #1;
         if (!p0[8] || mg0) p0 = {($urandom_range(0, 2) != 0), 8'($urandom)};
         if (!p1[8] || mg1) p1 = {($urandom_range(0, 2) != 0), 8'($urandom)};
         req0_opt_byte = p0;
         req1_opt_byte = p1;
      end
      step(9'h000, 9'h000);
      wait_idle("rand_drain");
      repeat (4) @(posedge CLK);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
